sbox6_inverse_lut: RTL and testbench
====================================

Name: sbox6_inverse_lut

Overview:
- Sequential inverse unit for the team's 6-bit GF(2^6) permutation S-boxes.
- On `start` it sweeps all 2^N inputs through an externally instantiated combinational forward S-box and builds the inverse table in registers.
- During the sweep it checks the forward map for bijectivity.
- Once built, it serves inverse lookups (y -> x) over a valid/ready handshake.
- Sits beside the forward S-box; the decrypt/inverse datapath uses it.

Parameters:
- N, 6, S-box width in bits; table depth is 2**N.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins or restarts a table build.
- fwd_x  out  N  sweep input driven to the external forward S-box.
- fwd_y  in  N  combinational forward S-box output for fwd_x, sampled in the same cycle.
- busy  out  1  build in progress.
- table_ok  out  1  table built and forward map bijective; lookups enabled.
- error  out  1  collision detected; table invalid.
- err_x  out  N  sweep input at which the collision was found.
- err_y  out  N  colliding output value.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  lookup request accepted.
- req_y  in  N  value to invert.
- resp_valid  out  1  lookup result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_x  out  N  inverse value, F^-1(req_y).

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; sweep counter 0.
  - All written flags cleared; table contents don't-care.
  - busy, table_ok, error, resp_valid all 0; err_x, err_y, resp_x, fwd_x all 0.
- States and transitions:
  - IDLE: start -> BUILD.
  - BUILD:
    - Each cycle fwd_x = cnt.
    - If written[fwd_y] is set: err_x<=cnt, err_y<=fwd_y, error<=1 -> ERROR.
    - Otherwise: tbl[fwd_y]<=cnt, written[fwd_y]<=1.
    - cnt == 2**N-1 with no collision -> DONE, table_ok<=1.
    - Otherwise cnt<=cnt+1.
  - DONE: serves lookups; start -> BUILD.
  - ERROR: start -> BUILD.
- Entering BUILD:
  - Clears every written flag, cnt, table_ok and error in the same edge.
  - Build takes exactly 2**N cycles (64 for N=6).
  - busy=1 from the cycle after start until DONE/ERROR is entered.
- start while in BUILD is ignored and does not restart the sweep.
- fwd_x = 0 outside BUILD.
- Exactly 2**N distinct writes imply a bijection, so no separate check pass is needed.
- Lookup path:
  - req_ready = (state==DONE) && (!resp_valid || resp_ready).
  - On req_valid && req_ready: resp_x<=tbl[req_y] and resp_valid<=1 at the next edge (1-cycle latency).
  - A new accept in the same cycle as resp_ready gives back-to-back throughput of 1 per cycle.
  - resp_valid clears on resp_ready when no new accept occurs.
  - resp_x is held stable while resp_valid && !resp_ready.
- start with a response pending:
  - resp_valid is dropped at the BUILD entry edge; the result is discarded.
  - Requests are not accepted again until DONE.
- Reset mid-build or mid-lookup:
  - Returns to IDLE immediately.
  - No partial table is ever reported as ok.
- Counter width is N bits. The terminal compare uses cnt == all-ones, so no wrap into a second pass.
- err_x and err_y are held until the next build starts.

Decomposition:
- Shared package `sbox6_pkg`:
  - SBOX_N = 6.
  - Typedef `sbox_word_t` = logic [SBOX_N-1:0].
  - State enum {IDLE, BUILD, DONE, ERROR}.
- One sub-module, `sbox6_inv_regfile`:
  - 2**N x N storage plus per-entry written flags.
  - One synchronous write port; one combinational read port for the lookup address and one for the collision probe.
  - Bulk flag clear.
- The forward S-box stays outside this block and is connected via fwd_x/fwd_y, so the same unit serves every S-box variant.

Test Plan:
- Stub fwd_y = fwd_x ^ 6'h2A; reset, pulse start:
  - busy high for 64 cycles, then table_ok=1 and error=0.
  - Lookup req_y=6'h00 -> resp_x=6'h2A; req_y=6'h3F -> resp_x=6'h15, each one cycle after accept.
- Stub fwd_y = fwd_x & 6'h3E; pulse start:
  - Collision at cnt=1, so error=1, err_x=6'h01, err_y=6'h00, table_ok=0.
  - ERROR is entered two cycles after start; req_ready stays 0.
- Bijective stub, DONE:
  - Stream 64 back-to-back requests with resp_ready=1 -> 64 responses on consecutive cycles, each matching a bench-built inverse.
  - Then hold resp_ready=0 for 5 cycles -> resp_x stable and req_ready=0.
- Pulse start again at cnt=20 during BUILD -> ignored; completion occurs at the original cycle 64.
- Assert rst_n=0 asynchronously at cnt=30:
  - All outputs 0 immediately.
  - A subsequent start rebuilds fully in 64 cycles with table_ok=1.
- In DONE with resp_valid=1 and resp_ready=0, pulse start:
  - resp_valid drops at the next edge and busy=1.
  - Swap the stub to fwd_y = ~fwd_x; after the rebuild, req_y=6'h00 -> resp_x=6'h3F.

Source files
------------

// File: rtl/sbox6_pkg.sv
// Shared definitions for the 6-bit S-box inverse builder: word width, word type
// and the builder state encoding.
package sbox6_pkg;

    localparam int SBOX_N = 6;

    typedef logic [SBOX_N-1:0] sbox_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/sbox6_inv_regfile.sv
// Inverse table storage: 2**N entries of N bits, one written flag per entry,
// a single write port, a lookup read port and a collision probe port.
module sbox6_inv_regfile
    import sbox6_pkg::*;
#(
    parameter int N = SBOX_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [N-1:0] i_waddr,
    input  logic [N-1:0] i_wdata,
    input  logic [N-1:0] i_raddr,
    output logic [N-1:0] o_rdata,
    input  logic [N-1:0] i_paddr,
    output logic         o_pwritten
);

    localparam int DEPTH = 2 ** N;

    logic [N-1:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_written;

    // Table data needs no reset: the written flags are what make an entry meaningful.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_written <= '0;
        end else if (i_clr) begin
            r_written <= '0;
        end else if (i_we) begin
            r_written[i_waddr] <= 1'b1;
        end
    end

    assign o_rdata    = r_mem[i_raddr];
    assign o_pwritten = r_written[i_paddr];

endmodule

// File: rtl/sbox6_inverse_lut.sv
// Builds the inverse of an external forward S-box by sweeping every input once,
// flags non-bijective maps, then serves y -> x lookups over valid/ready.
module sbox6_inverse_lut
    import sbox6_pkg::*;
#(
    parameter int N = SBOX_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    output logic [N-1:0] o_fwd_x,
    input  logic [N-1:0] i_fwd_y,
    output logic         o_busy,
    output logic         o_table_ok,
    output logic         o_error,
    output logic [N-1:0] o_err_x,
    output logic [N-1:0] o_err_y,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [N-1:0] i_req_y,
    output logic         o_resp_valid,
    input  logic         i_resp_ready,
    output logic [N-1:0] o_resp_x
);

    state_t       r_state;
    state_t       w_next_state;
    logic [N-1:0] r_cnt;
    logic         r_table_ok;
    logic         r_error;
    logic [N-1:0] r_err_x;
    logic [N-1:0] r_err_y;
    logic         r_resp_valid;
    logic [N-1:0] r_resp_x;

    logic         w_build_start;
    logic         w_in_build;
    logic         w_probe_written;
    logic         w_collide;
    logic         w_we;
    logic         w_cnt_last;
    logic         w_req_ready;
    logic         w_accept;
    logic [N-1:0] w_rdata;

    assign w_in_build    = (r_state == BUILD);
    assign w_build_start = i_start && !w_in_build;
    assign w_collide     = w_in_build && w_probe_written;
    assign w_we          = w_in_build && !w_probe_written;
    assign w_cnt_last    = (r_cnt == '1);
    assign w_req_ready   = (r_state == DONE) && (!r_resp_valid || i_resp_ready);
    assign w_accept      = i_req_valid && w_req_ready;

    sbox6_inv_regfile #(.N(N)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_build_start),
        .i_we       (w_we),
        .i_waddr    (i_fwd_y),
        .i_wdata    (r_cnt),
        .i_raddr    (i_req_y),
        .o_rdata    (w_rdata),
        .i_paddr    (i_fwd_y),
        .o_pwritten (w_probe_written)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next_state = BUILD;
            BUILD: begin
                if (w_collide)       w_next_state = ERROR;
                else if (w_cnt_last) w_next_state = DONE;
            end
            DONE:    if (i_start) w_next_state = BUILD;
            ERROR:   if (i_start) w_next_state = BUILD;
            default: w_next_state = IDLE;
        endcase
    end

    // A build start wipes every result of the previous run, including a pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_table_ok   <= 1'b0;
            r_error      <= 1'b0;
            r_err_x      <= '0;
            r_err_y      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_x     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_build_start) begin
                r_cnt        <= '0;
                r_table_ok   <= 1'b0;
                r_error      <= 1'b0;
                r_err_x      <= '0;
                r_err_y      <= '0;
                r_resp_valid <= 1'b0;
            end else begin
                if (w_in_build) begin
                    if (w_collide) begin
                        r_err_x <= r_cnt;
                        r_err_y <= i_fwd_y;
                        r_error <= 1'b1;
                    end else if (w_cnt_last) begin
                        r_table_ok <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (w_accept) begin
                    r_resp_valid <= 1'b1;
                    r_resp_x     <= w_rdata;
                end else if (i_resp_ready) begin
                    r_resp_valid <= 1'b0;
                end
            end
        end
    end

    assign o_fwd_x      = w_in_build ? r_cnt : '0;
    assign o_busy       = w_in_build;
    assign o_table_ok   = r_table_ok;
    assign o_error      = r_error;
    assign o_err_x      = r_err_x;
    assign o_err_y      = r_err_y;
    assign o_req_ready  = w_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_x     = r_resp_x;

endmodule

// File: tb/tb_sbox6_inverse_lut.sv
// Directed bench for the inverse S-box builder: drives a software forward S-box
// stub and scoreboards every lookup response against a bench-built inverse.
module tb_sbox6_inverse_lut;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] fwd_x;
    logic [5:0] fwd_y;
    logic       busy;
    logic       table_ok;
    logic       error;
    logic [5:0] err_x;
    logic [5:0] err_y;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_y;
    logic       resp_valid;
    logic       resp_ready;
    logic [5:0] resp_x;

    int         mode;
    int         testCount;
    int         failCount;
    int         popCount;
    int         buildCycles;
    int         popsBefore;
    logic [5:0] invModel [64];
    logic [5:0] expQ [$];

    sbox6_inverse_lut dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .o_fwd_x      (fwd_x),
        .i_fwd_y      (fwd_y),
        .o_busy       (busy),
        .o_table_ok   (table_ok),
        .o_error      (error),
        .o_err_x      (err_x),
        .o_err_y      (err_y),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_y      (req_y),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_x     (resp_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: xor 2A (bijective), 1: and 3E (collides), 2: bitwise not (bijective).
    function automatic logic [5:0] fwdModel(input int m, input logic [5:0] x);
        case (m)
            0:       return x ^ 6'h2A;
            1:       return x & 6'h3E;
            default: return ~x;
        endcase
    endfunction

    always_comb fwd_y = fwdModel(mode, fwd_x);

    task automatic buildModel();
        for (int x = 0; x < 64; x++) begin
            logic [5:0] xv;
            xv = x[5:0];
            invModel[fwdModel(mode, xv)] = xv;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge with inputs set; records handshakes, then advances one cycle.
    task automatic applyStimulus();
        #1;
        if (resp_valid && resp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboard_underflow", expQ.size(), 1);
            end else begin
                checkOutput("resp_x_scoreboard", resp_x, expQ.pop_front());
                popCount++;
            end
        end
        if (req_valid && req_ready) expQ.push_back(invModel[req_y]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
    endtask

    task automatic waitBuild(input int pulseAt, output int n);
        n = 0;
        while (busy && n < 200) begin
            checkOutput("fwd_x_sweep", fwd_x, n);
            start = (n == pulseAt);
            applyStimulus();
            n++;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, failed %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testCount  = 0;
        failCount  = 0;
        popCount   = 0;
        mode       = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        req_valid  = 1'b0;
        req_y      = '0;
        resp_ready = 1'b0;
        buildModel();

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_table_ok", table_ok, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_resp_valid", resp_valid, 0);
        checkOutput("reset_fwd_x", fwd_x, 0);
        checkOutput("reset_err_x", err_x, 0);
        checkOutput("reset_err_y", err_y, 0);
        checkOutput("reset_resp_x", resp_x, 0);
        checkOutput("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First build with xor stub.
        pulseStart();
        checkOutput("build_busy_after_start", busy, 1);
        waitBuild(-1, buildCycles);
        checkOutput("build_cycles", buildCycles, 64);
        checkOutput("build_table_ok", table_ok, 1);
        checkOutput("build_error", error, 0);

        // Single lookups, then a back-to-back pair.
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_y      = 6'h00;
        applyStimulus();
        req_valid  = 1'b0;
        checkOutput("lookup00_valid", resp_valid, 1);
        checkOutput("lookup00_x", resp_x, 6'h2A);
        req_valid  = 1'b1;
        req_y      = 6'h3F;
        applyStimulus();
        req_valid  = 1'b0;
        checkOutput("lookup3F_valid", resp_valid, 1);
        checkOutput("lookup3F_x", resp_x, 6'h15);
        applyStimulus();
        checkOutput("lookup_drained_valid", resp_valid, 0);

        // Stream 64 requests with one accept per cycle.
        popsBefore = popCount;
        for (int i = 0; i < 64; i++) begin
            req_valid = 1'b1;
            req_y     = 6'(i);
            #1;
            checkOutput("stream_req_ready", req_ready, 1);
            if (i > 0) checkOutput("stream_resp_valid", resp_valid, 1);
            applyStimulus();
        end
        req_valid = 1'b0;
        applyStimulus();
        checkOutput("stream_resp_count", popCount - popsBefore, 64);
        checkOutput("stream_queue_empty", expQ.size(), 0);

        // Backpressure: response must hold, no new accepts.
        req_valid  = 1'b1;
        req_y      = 6'h05;
        resp_ready = 1'b0;
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_req_ready", req_ready, 0);
            checkOutput("stall_resp_valid", resp_valid, 1);
            checkOutput("stall_resp_x", resp_x, 6'h2F);
            applyStimulus();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        applyStimulus();
        checkOutput("stall_queue_empty", expQ.size(), 0);

        // Collision stub: error two cycles after start.
        mode = 1;
        pulseStart();
        checkOutput("coll_busy0", busy, 1);
        applyStimulus();
        checkOutput("coll_busy1", busy, 1);
        checkOutput("coll_error_early", error, 0);
        applyStimulus();
        checkOutput("coll_error", error, 1);
        checkOutput("coll_err_x", err_x, 6'h01);
        checkOutput("coll_err_y", err_y, 6'h00);
        checkOutput("coll_table_ok", table_ok, 0);
        checkOutput("coll_busy_done", busy, 0);
        req_valid = 1'b1;
        #1;
        checkOutput("coll_req_ready", req_ready, 0);
        applyStimulus();
        req_valid = 1'b0;

        // Restart attempt mid-build is ignored.
        mode = 0;
        buildModel();
        pulseStart();
        waitBuild(20, buildCycles);
        checkOutput("restart_ignored_cycles", buildCycles, 64);
        checkOutput("restart_table_ok", table_ok, 1);
        checkOutput("restart_error", error, 0);

        // Asynchronous reset in the middle of a build.
        pulseStart();
        for (int i = 0; i < 30; i++) applyStimulus();
        checkOutput("midreset_fwd_x_before", fwd_x, 30);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_table_ok", table_ok, 0);
        checkOutput("midreset_error", error, 0);
        checkOutput("midreset_resp_valid", resp_valid, 0);
        checkOutput("midreset_fwd_x", fwd_x, 0);
        checkOutput("midreset_resp_x", resp_x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulseStart();
        waitBuild(-1, buildCycles);
        checkOutput("postreset_cycles", buildCycles, 64);
        checkOutput("postreset_table_ok", table_ok, 1);

        // Start with a response pending discards it and rebuilds with the not stub.
        req_valid  = 1'b1;
        req_y      = 6'h03;
        resp_ready = 1'b0;
        applyStimulus();
        req_valid  = 1'b0;
        checkOutput("pending_resp_valid", resp_valid, 1);
        mode = 2;
        pulseStart();
        checkOutput("pending_dropped", resp_valid, 0);
        checkOutput("pending_busy", busy, 1);
        expQ.delete();
        buildModel();
        waitBuild(-1, buildCycles);
        checkOutput("not_cycles", buildCycles, 64);
        checkOutput("not_table_ok", table_ok, 1);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_y      = 6'h00;
        applyStimulus();
        req_valid  = 1'b0;
        checkOutput("not_lookup00", resp_x, 6'h3F);
        applyStimulus();
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
